board_debouncer: RTL and testbench

Conditions the raw 32-square reed-sensor snapshot from the sensor shift-register reader and the physical move button before they reach the memory manager. It synchronises and debounces both the board and the button. On each debounced button press it emits a one-cycle move strobe with lifted/placed square masks, computed against the board as it stood at the previous press. It sits between SensorManager's `sensorDataOut` and MemoryManager's `sensorBoardIn`/`buttonPressIn`.

---
 rtl/board_debouncer.sv | 184 ++++++++++++++++++
 tb/tb_board_debouncer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/board_debouncer.sv
// Debounces the 32-square reed-sensor board and the move button, then emits a move strobe with lifted/placed masks.
// BOARD_DEBOUNCE_FAST_SIM_EN forces the stable counts to 4 (board) and 8 (button) for fast simulation.
module board_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int BTN_CYCLES    = 2000000,
    parameter int CNT_W         = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] sensorIn,
    input  logic        buttonIn,
    output logic [31:0] boardOut,
    output logic        boardValid,
    output logic        buttonLevel,
    output logic        moveStrobe,
    output logic [31:0] liftedMask,
    output logic [31:0] placedMask,
    output logic [1:0]  debugState
);

`ifdef BOARD_DEBOUNCE_FAST_SIM_EN
    localparam int BOARD_EFF = 4;
    localparam int BTN_EFF   = 8;
`else
    localparam int BOARD_EFF = STABLE_CYCLES;
    localparam int BTN_EFF   = BTN_CYCLES;
`endif

    localparam logic [CNT_W-1:0] BOARD_MAX = CNT_W'(BOARD_EFF - 1);
    localparam logic [CNT_W-1:0] BTN_MAX   = CNT_W'(BTN_EFF - 1);

    typedef enum logic [1:0] {
        WAIT_BOARD = 2'd0,
        ARMED      = 2'd1,
        HELD       = 2'd2
    } state_e;

    logic [31:0]      sens_s1_q, sens_s2_q;
    logic             btn_s1_q, btn_s2_q;

    logic [31:0]      board_cand_q, board_cand_d;
    logic [CNT_W-1:0] board_cnt_q, board_cnt_d;
    logic [31:0]      board_q, board_d;
    logic             valid_q, valid_d;

    logic             btn_cand_q, btn_cand_d;
    logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             btn_prev_q;
    logic             btn_released_q, btn_released_d;

    state_e           state_q, state_d;
    logic [31:0]      baseline_q, baseline_d;
    logic             strobe_q, strobe_d;
    logic [31:0]      lifted_q, lifted_d;
    logic [31:0]      placed_q, placed_d;
    logic             press;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sens_s1_q <= '0;
            sens_s2_q <= '0;
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
        end else begin
            sens_s1_q <= sensorIn;
            sens_s2_q <= sens_s1_q;
            btn_s1_q  <= buttonIn;
            btn_s2_q  <= btn_s1_q;
        end
    end

    // Board: any sample differing from the candidate restarts the count; commit once it saturates.
    always_comb begin
        board_cand_d = board_cand_q;
        board_cnt_d  = board_cnt_q;
        board_d      = board_q;
        valid_d      = valid_q;
        if (sens_s2_q != board_cand_q) begin
            board_cand_d = sens_s2_q;
            board_cnt_d  = '0;
        end else if (board_cnt_q != BOARD_MAX) begin
            board_cnt_d = board_cnt_q + CNT_W'(1);
        end else begin
            board_d = board_cand_q;
            valid_d = 1'b1;
        end
    end

    // A held button only becomes pressable after a debounced low has been seen since reset.
    always_comb begin
        btn_cand_d     = btn_cand_q;
        btn_cnt_d      = btn_cnt_q;
        btn_level_d    = btn_level_q;
        btn_released_d = btn_released_q;
        if (btn_s2_q != btn_cand_q) begin
            btn_cand_d = btn_s2_q;
            btn_cnt_d  = '0;
        end else if (btn_cnt_q != BTN_MAX) begin
            btn_cnt_d = btn_cnt_q + CNT_W'(1);
        end else begin
            btn_level_d = btn_cand_q;
            if (!btn_cand_q) begin
                btn_released_d = 1'b1;
            end
        end
    end

    assign press = btn_level_q & ~btn_prev_q & btn_released_q;

    always_comb begin
        state_d    = state_q;
        baseline_d = baseline_q;
        strobe_d   = 1'b0;
        lifted_d   = lifted_q;
        placed_d   = placed_q;
        case (state_q)
            WAIT_BOARD: begin
                if (valid_q) begin
                    state_d    = ARMED;
                    baseline_d = board_q;
                end
            end
            ARMED: begin
                if (press) begin
                    strobe_d   = 1'b1;
                    lifted_d   = baseline_q & ~board_q;
                    placed_d   = ~baseline_q & board_q;
                    baseline_d = board_q;
                    state_d    = HELD;
                end
            end
            HELD: begin
                if (!btn_level_q) begin
                    state_d = ARMED;
                end
            end
            default: state_d = WAIT_BOARD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            board_cand_q   <= '0;
            board_cnt_q    <= '0;
            board_q        <= '0;
            valid_q        <= 1'b0;
            btn_cand_q     <= 1'b0;
            btn_cnt_q      <= '0;
            btn_level_q    <= 1'b0;
            btn_prev_q     <= 1'b0;
            btn_released_q <= 1'b0;
            state_q        <= WAIT_BOARD;
            baseline_q     <= '0;
            strobe_q       <= 1'b0;
            lifted_q       <= '0;
            placed_q       <= '0;
        end else begin
            board_cand_q   <= board_cand_d;
            board_cnt_q    <= board_cnt_d;
            board_q        <= board_d;
            valid_q        <= valid_d;
            btn_cand_q     <= btn_cand_d;
            btn_cnt_q      <= btn_cnt_d;
            btn_level_q    <= btn_level_d;
            btn_prev_q     <= btn_level_q;
            btn_released_q <= btn_released_d;
            state_q        <= state_d;
            baseline_q     <= baseline_d;
            strobe_q       <= strobe_d;
            lifted_q       <= lifted_d;
            placed_q       <= placed_d;
        end
    end

    assign boardOut    = board_q;
    assign boardValid  = valid_q;
    assign buttonLevel = btn_level_q;
    assign moveStrobe  = strobe_q;
    assign liftedMask  = lifted_q;
    assign placedMask  = placed_q;
    assign debugState  = state_q;

endmodule

// File: tb/tb_board_debouncer.sv
// Directed bench for board_debouncer with STABLE_CYCLES=4 and BTN_CYCLES=8.
module tb_board_debouncer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] sensorIn = '0;
    logic        buttonIn = 1'b0;
    logic [31:0] boardOut;
    logic        boardValid;
    logic        buttonLevel;
    logic        moveStrobe;
    logic [31:0] liftedMask;
    logic [31:0] placedMask;
    logic [1:0]  debugState;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int base = 0;

    board_debouncer #(
        .STABLE_CYCLES(4),
        .BTN_CYCLES   (8),
        .CNT_W        (24)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sensorIn   (sensorIn),
        .buttonIn   (buttonIn),
        .boardOut   (boardOut),
        .boardValid (boardValid),
        .buttonLevel(buttonLevel),
        .moveStrobe (moveStrobe),
        .liftedMask (liftedMask),
        .placedMask (placedMask),
        .debugState (debugState)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && moveStrobe) strobe_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; sensorIn = 32'h0000_0FFF; buttonIn = 1'b0;
        step(3);
        checks++; if (boardOut !== 32'h0) begin errors++; $display("FAIL rst_board: got %h expected %h", boardOut, 32'h0); end
        checks++; if (boardValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", boardValid); end
        checks++; if (buttonLevel !== 1'b0) begin errors++; $display("FAIL rst_btn: got %b expected 0", buttonLevel); end
        checks++; if (moveStrobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", moveStrobe); end
        checks++; if ({liftedMask, placedMask} !== 64'h0) begin errors++; $display("FAIL rst_masks: got %h/%h expected 0/0", liftedMask, placedMask); end
        checks++; if (debugState !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", debugState); end
        reset = 1'b1;
        step(6);
        checks++; if (boardValid !== 1'b0) begin errors++; $display("FAIL commit_early_valid: got %b expected 0", boardValid); end
        checks++; if (boardOut !== 32'h0) begin errors++; $display("FAIL commit_early_board: got %h expected %h", boardOut, 32'h0); end
        step(1);
        checks++; if (boardValid !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b expected 1", boardValid); end
        checks++; if (boardOut !== 32'h0000_0FFF) begin errors++; $display("FAIL commit_board: got %h expected %h", boardOut, 32'h0000_0FFF); end
        step(1);
        checks++; if (debugState !== 2'd1) begin errors++; $display("FAIL armed_state: got %0d expected 1", debugState); end
    endtask

    task automatic test_bounce;
        base = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            sensorIn = (i % 2 == 0) ? 32'h0000_0FFE : 32'h0000_0FFF;
            step(3);
        end
        checks++; if (boardOut !== 32'h0000_0FFF) begin errors++; $display("FAIL bounce_hold: got %h expected %h", boardOut, 32'h0000_0FFF); end
        sensorIn = 32'h0000_0FFE;
        step(6);
        checks++; if (boardOut !== 32'h0000_0FFF) begin errors++; $display("FAIL bounce_early: got %h expected %h", boardOut, 32'h0000_0FFF); end
        step(1);
        checks++; if (boardOut !== 32'h0000_0FFE) begin errors++; $display("FAIL bounce_settle: got %h expected %h", boardOut, 32'h0000_0FFE); end
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL bounce_strobes: got %0d expected 0", strobe_cnt - base); end
    endtask

    task automatic test_move;
        sensorIn = 32'h0001_0FFE;
        step(8);
        checks++; if (boardOut !== 32'h0001_0FFE) begin errors++; $display("FAIL move_board: got %h expected %h", boardOut, 32'h0001_0FFE); end
        base = strobe_cnt;
        buttonIn = 1'b1;
        step(11);
        checks++; if (buttonLevel !== 1'b1) begin errors++; $display("FAIL move_level: got %b expected 1", buttonLevel); end
        checks++; if (moveStrobe !== 1'b0) begin errors++; $display("FAIL move_strobe_early: got %b expected 0", moveStrobe); end
        step(1);
        checks++; if (moveStrobe !== 1'b1) begin errors++; $display("FAIL move_strobe: got %b expected 1", moveStrobe); end
        checks++; if (liftedMask !== 32'h0000_0001) begin errors++; $display("FAIL move_lifted: got %h expected %h", liftedMask, 32'h0000_0001); end
        checks++; if (placedMask !== 32'h0001_0000) begin errors++; $display("FAIL move_placed: got %h expected %h", placedMask, 32'h0001_0000); end
        step(1);
        checks++; if (moveStrobe !== 1'b0) begin errors++; $display("FAIL move_strobe_width: got %b expected 0", moveStrobe); end
        checks++; if (debugState !== 2'd2) begin errors++; $display("FAIL move_held: got %0d expected 2", debugState); end
        step(7);
        checks++; if (strobe_cnt - base != 1) begin errors++; $display("FAIL move_single: got %0d expected 1", strobe_cnt - base); end
        buttonIn = 1'b0;
        step(12);
        checks++; if (debugState !== 2'd1) begin errors++; $display("FAIL release_armed: got %0d expected 1", debugState); end
        checks++; if (liftedMask !== 32'h0000_0001) begin errors++; $display("FAIL mask_hold: got %h expected %h", liftedMask, 32'h0000_0001); end
        buttonIn = 1'b1; step(12);
        buttonIn = 1'b0; step(12);
        checks++; if (strobe_cnt - base != 2) begin errors++; $display("FAIL back_to_back_count: got %0d expected 2", strobe_cnt - base); end
        checks++; if ({liftedMask, placedMask} !== 64'h0) begin errors++; $display("FAIL empty_move_masks: got %h/%h expected 0/0", liftedMask, placedMask); end
    endtask

    task automatic test_chatter;
        base = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            buttonIn = 1'b1; step(5);
            buttonIn = 1'b0; step(5);
            checks++; if (buttonLevel !== 1'b0) begin errors++; $display("FAIL chatter_level: got %b expected 0", buttonLevel); end
        end
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL chatter_strobes: got %0d expected 0", strobe_cnt - base); end
        buttonIn = 1'b1; step(12);
        buttonIn = 1'b0; step(12);
        checks++; if (strobe_cnt - base != 1) begin errors++; $display("FAIL clean_press: got %0d expected 1", strobe_cnt - base); end
    endtask

    task automatic test_press_before_commit;
        reset = 1'b0; sensorIn = 32'h5; buttonIn = 1'b0;
        step(2);
        reset = 1'b1;
        base = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            sensorIn = (i % 2 == 1) ? 32'hA : 32'h5;
            if (i == 5) buttonIn = 1'b1;
            step(2);
        end
        checks++; if (buttonLevel !== 1'b1) begin errors++; $display("FAIL early_level: got %b expected 1", buttonLevel); end
        checks++; if (boardValid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b expected 0", boardValid); end
        checks++; if (debugState !== 2'd0) begin errors++; $display("FAIL early_state: got %0d expected 0", debugState); end
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL early_strobes: got %0d expected 0", strobe_cnt - base); end
        sensorIn = 32'h5; buttonIn = 1'b0;
        step(12);
        checks++; if (boardOut !== 32'h5) begin errors++; $display("FAIL early_board: got %h expected %h", boardOut, 32'h5); end
        checks++; if (debugState !== 2'd1) begin errors++; $display("FAIL early_armed: got %0d expected 1", debugState); end
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL early_strobes_after: got %0d expected 0", strobe_cnt - base); end
    endtask

    task automatic test_reset_held;
        sensorIn = 32'h6;
        step(8);
        base = strobe_cnt;
        buttonIn = 1'b1;
        step(13);
        checks++; if (strobe_cnt - base != 1) begin errors++; $display("FAIL held_pre_strobe: got %0d expected 1", strobe_cnt - base); end
        checks++; if ({liftedMask, placedMask} !== {32'h1, 32'h2}) begin errors++; $display("FAIL held_pre_masks: got %h/%h expected 1/2", liftedMask, placedMask); end
        checks++; if (debugState !== 2'd2) begin errors++; $display("FAIL held_state: got %0d expected 2", debugState); end
        reset = 1'b0;
        #2;
        checks++; if (debugState !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", debugState); end
        checks++; if ({boardValid, buttonLevel, moveStrobe} !== 3'b000) begin errors++; $display("FAIL async_flags: got %b expected 000", {boardValid, buttonLevel, moveStrobe}); end
        checks++; if ({boardOut, liftedMask, placedMask} !== 96'h0) begin errors++; $display("FAIL async_data: got %h/%h/%h expected 0/0/0", boardOut, liftedMask, placedMask); end
        step(1);
        reset = 1'b1;
        base = strobe_cnt;
        step(20);
        checks++; if (boardOut !== 32'h6) begin errors++; $display("FAIL post_board: got %h expected %h", boardOut, 32'h6); end
        checks++; if (buttonLevel !== 1'b1) begin errors++; $display("FAIL post_level: got %b expected 1", buttonLevel); end
        checks++; if (debugState !== 2'd1) begin errors++; $display("FAIL post_state: got %0d expected 1", debugState); end
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL post_no_strobe: got %0d expected 0", strobe_cnt - base); end
        buttonIn = 1'b0; step(5);
        buttonIn = 1'b1; step(14);
        checks++; if (strobe_cnt != base) begin errors++; $display("FAIL short_release: got %0d expected 0", strobe_cnt - base); end
        buttonIn = 1'b0; sensorIn = 32'h3;
        step(12);
        checks++; if (buttonLevel !== 1'b0) begin errors++; $display("FAIL long_release: got %b expected 0", buttonLevel); end
        buttonIn = 1'b1;
        step(13);
        checks++; if (strobe_cnt - base != 1) begin errors++; $display("FAIL repress: got %0d expected 1", strobe_cnt - base); end
        checks++; if ({liftedMask, placedMask} !== {32'h4, 32'h1}) begin errors++; $display("FAIL repress_masks: got %h/%h expected 4/1", liftedMask, placedMask); end
        buttonIn = 1'b0;
        step(12);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_move();
        test_chatter();
        test_press_before_commit();
        test_reset_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
